pe_network_interface: RTL and testbench

//  PE-side network interface for the cardinal mesh. It is the far end of a router's PE port.
//  - Injects processor-written packets into the router via net_so/net_ro/net_do.
//  - Ejects router-delivered packets via net_si/net_ri/net_di into a buffer the processor reads.
//  - Processor side is a 2-bit-addressed register port.
//  - Injection is gated by router polarity so each packet enters on its own virtual channel.

---
 rtl/noc_pkg.sv | 13 +
 rtl/nic_fifo.sv | 58 +++++
 rtl/pe_network_interface.sv | 91 +++++++++
 tb/tb_pe_network_interface.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared constants for the cardinal mesh PE network interface.
package noc_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned VC_BIT     = 63;
    localparam int unsigned BUF_DEPTH  = 2;

    localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
    localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
    localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

endpackage

// File: rtl/nic_fifo.sv
// Small circular FIFO used for both directions of the network interface.
// Push while full and pop while empty are ignored; head reads 0 when empty.
module nic_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  nonempty
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == CNT_W'(BUF_DEPTH));
    assign nonempty = (count != '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & nonempty;
    assign head     = nonempty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked to 0 whenever count is 0.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pe_network_interface.sv
// PE-side network interface: register port to the processor, inject/eject
// FIFOs to the router, with injection gated by router polarity per VC.
module pe_network_interface
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = noc_pkg::DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = noc_pkg::BUF_DEPTH,
    parameter int unsigned VC_BIT     = noc_pkg::VC_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  net_polarity,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEN,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);

    logic                  rd_en;
    logic                  wr_en;
    logic                  in_pop;
    logic                  in_push;
    logic [DATA_WIDTH-1:0] in_head;
    logic                  in_full;
    logic                  in_nonempty;
    logic                  out_push;
    logic [DATA_WIDTH-1:0] out_head;
    logic                  out_full;
    logic                  out_nonempty;

    assign rd_en    = nicEN & ~nicWrEn;
    assign wr_en    = nicEN & nicWrEn;
    assign in_pop   = rd_en & (addr == ADDR_IN_BUF);
    assign out_push = wr_en & (addr == ADDR_OUT_BUF);

    // A full IN FIFO refuses the router even if the processor pops this cycle.
    assign net_ri  = reset & ~in_full;
    assign in_push = net_si & net_ri;

    assign net_do = out_head;
    assign net_so = out_nonempty & net_ro & (net_polarity == out_head[VC_BIT]);

    nic_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_push),
        .pop     (in_pop),
        .din     (net_di),
        .head    (in_head),
        .full    (in_full),
        .nonempty(in_nonempty)
    );

    nic_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (out_push),
        .pop     (net_so),
        .din     (d_in),
        .head    (out_head),
        .full    (out_full),
        .nonempty(out_nonempty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            case (addr)
                ADDR_IN_BUF:   d_out <= in_head;
                ADDR_IN_STAT:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_nonempty};
                ADDR_OUT_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_network_interface.sv
// Self-checking bench for pe_network_interface: vector table plus
// scoreboards for processor reads and router-bound packets.
module tb_pe_network_interface;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        net_polarity;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEN;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    always #5 clk = ~clk;

    pe_network_interface #(
        .DATA_WIDTH(64),
        .BUF_DEPTH (2),
        .VC_BIT    (63)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .net_polarity(net_polarity),
        .addr        (addr),
        .d_in        (d_in),
        .d_out       (d_out),
        .nicEN       (nicEN),
        .nicWrEn     (nicWrEn),
        .net_so      (net_so),
        .net_ro      (net_ro),
        .net_do      (net_do),
        .net_si      (net_si),
        .net_ri      (net_ri),
        .net_di      (net_di)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          so_cnt   = 0;
    logic [63:0] rd_q[$];
    logic [63:0] tx_q[$];
    logic        rd_pend  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= nicEN && !nicWrEn && reset;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_unexpected: actual=%h required=<no read pending>", d_out);
            end else begin
                chk("rd_data", d_out, rd_q.pop_front());
            end
        end
        if (net_so) begin
            so_cnt++;
            if (tx_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx_unexpected: actual=%h required=<no send>", net_do);
            end else begin
                chk("tx_data", net_do, tx_q.pop_front());
                chk("tx_vc", {63'b0, net_polarity}, {63'b0, net_do[63]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        net_polarity = ~net_polarity;
    endtask

    task automatic do_read(input logic [1:0] a, input logic [63:0] exp);
        nicEN = 1'b1; nicWrEn = 1'b0; addr = a;
        rd_q.push_back(exp);
        tick();
        nicEN = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [63:0] data);
        nicEN = 1'b1; nicWrEn = 1'b1; addr = a; d_in = data;
        if (a == ADDR_OUT_BUF && tx_q.size() < 2) tx_q.push_back(data);
        tick();
        nicEN = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic router_push(input logic [63:0] data);
        net_si = 1'b1; net_di = data;
        tick();
        net_si = 1'b0;
    endtask

    localparam logic [1:0] K_PUSH = 2'd0, K_READ = 2'd1, K_WRITE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  a;
        logic [63:0] data;
        logic [63:0] exp;
        logic        ri;
    } vec_t;

    vec_t vt[14];

    initial begin
        int base;
        vt[0]  = '{K_PUSH,  2'd0, 64'h1234, 64'h0,    1'b1};
        vt[1]  = '{K_READ,  2'd1, 64'h0,    64'h1,    1'b1};
        vt[2]  = '{K_READ,  2'd0, 64'h0,    64'h1234, 1'b1};
        vt[3]  = '{K_READ,  2'd1, 64'h0,    64'h0,    1'b1};
        vt[4]  = '{K_READ,  2'd0, 64'h0,    64'h0,    1'b1};
        vt[5]  = '{K_READ,  2'd1, 64'h0,    64'h0,    1'b1};
        vt[6]  = '{K_WRITE, 2'd0, 64'hFFFF, 64'h0,    1'b1};
        vt[7]  = '{K_WRITE, 2'd1, 64'hFFFF, 64'h0,    1'b1};
        vt[8]  = '{K_WRITE, 2'd3, 64'hFFFF, 64'h0,    1'b1};
        vt[9]  = '{K_READ,  2'd1, 64'h0,    64'h0,    1'b1};
        vt[10] = '{K_READ,  2'd2, 64'h0,    64'h0,    1'b1};
        vt[11] = '{K_PUSH,  2'd0, 64'h55,   64'h0,    1'b1};
        vt[12] = '{K_READ,  2'd0, 64'h0,    64'h55,   1'b1};
        vt[13] = '{K_READ,  2'd3, 64'h0,    64'h0,    1'b1};

        reset = 1'b0; net_polarity = 1'b0; addr = '0; d_in = '0;
        nicEN = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0; net_si = 1'b0; net_di = '0;
        #1;
        chk("rst_so", {63'b0, net_so}, 64'h0);
        chk("rst_ri", {63'b0, net_ri}, 64'h0);
        chk("rst_dout", d_out, 64'h0);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("ri_after_rst", {63'b0, net_ri}, 64'h1);

        // Reset mid-operation with a packet queued and the router ready
        router_push(64'h77);
        do_read(ADDR_IN_STAT, 64'h1);
        do_write(ADDR_OUT_BUF, 64'h99);
        reset = 1'b0; net_ro = 1'b1;
        #1;
        chk("midrst_so", {63'b0, net_so}, 64'h0);
        chk("midrst_ri", {63'b0, net_ri}, 64'h0);
        chk("midrst_dout", d_out, 64'h0);
        tx_q.delete();
        tick(); tick();
        reset = 1'b1;
        do_read(ADDR_IN_STAT, 64'h0);
        do_read(ADDR_OUT_STAT, 64'h0);

        // VC gating: odd-VC packet written on an even cycle
        net_ro = 1'b1;
        for (int i = 0; i < 2 && net_polarity != 1'b0; i++) tick();
        base = so_cnt;
        nicEN = 1'b1; nicWrEn = 1'b1; addr = ADDR_OUT_BUF; d_in = 64'h8000_0000_0000_00AB;
        tx_q.push_back(64'h8000_0000_0000_00AB);
        #1;
        chk("vc_so_write_cycle", {63'b0, net_so}, 64'h0);
        tick();
        nicEN = 1'b0; nicWrEn = 1'b0;
        tick(); tick(); tick();
        chk("vc_send_count", 64'(so_cnt - base), 64'd1);
        do_read(ADDR_OUT_STAT, 64'h0);

        // OUT full: third write is dropped, then drain in order
        net_ro = 1'b0;
        do_write(ADDR_OUT_BUF, 64'h11);
        do_write(ADDR_OUT_BUF, 64'h22);
        do_write(ADDR_OUT_BUF, 64'h33);
        do_read(ADDR_OUT_STAT, 64'h1);
        base = so_cnt;
        net_ro = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("full_send_count", 64'(so_cnt - base), 64'd2);
        chk("full_txq_empty", 64'(tx_q.size()), 64'd0);
        do_read(ADDR_OUT_STAT, 64'h0);
        net_ro = 1'b0;

        // Eject / underflow / ignored writes
        for (int i = 0; i < 14; i++) begin
            case (vt[i].kind)
                K_PUSH:  router_push(vt[i].data);
                K_READ:  do_read(vt[i].a, vt[i].exp);
                default: do_write(vt[i].a, vt[i].data);
            endcase
            chk($sformatf("vec%0d_ri", i), {63'b0, net_ri}, {63'b0, vt[i].ri});
        end

        // IN full with a simultaneous processor pop and router send
        router_push(64'hA1);
        router_push(64'hB2);
        chk("in_full_ri", {63'b0, net_ri}, 64'h0);
        nicEN = 1'b1; nicWrEn = 1'b0; addr = ADDR_IN_BUF;
        rd_q.push_back(64'hA1);
        net_si = 1'b1; net_di = 64'hC3;
        #1;
        chk("pop_cycle_ri", {63'b0, net_ri}, 64'h0);
        tick();
        nicEN = 1'b0;
        #1;
        chk("ri_rises", {63'b0, net_ri}, 64'h1);
        tick();
        net_si = 1'b0;
        do_read(ADDR_IN_BUF, 64'hB2);
        do_read(ADDR_IN_BUF, 64'hC3);
        do_read(ADDR_IN_STAT, 64'h0);

        tick(); tick(); tick();
        chk("rdq_drained", 64'(rd_q.size()), 64'd0);
        chk("txq_drained", 64'(tx_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
